dds_serial_rx: RTL
==================

# dds_serial_rx

Receive side of the 3-wire DDS serial link (FSYNC/SCLK/SDATA, AD9833 framing: 16-bit words, MSB first, data valid on SCLK falling edge while FSYNC low). Oversamples the link in the system clock domain, deserialises words into a small FIFO, and exposes them to the PicoBlaze through the `port_id`/`in_port`/`read_strobe` input-port bus. Used as a loopback monitor for the `dds` transmitter and as a bench checker for DDS register writes.

## Interface
- `BASE_PORT`, default 8'h10: PicoBlaze port base. Offsets:
  - +0 word low byte
  - +1 word high byte (pop)
  - +2 status
- `FIFO_DEPTH`, default 4: word FIFO depth. Must be a power of 2, ≥2.

- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `FSYNC`  in  1  frame sync, active low, asynchronous to `clk`.
- `SCLK`  in  1  serial clock, asynchronous to `clk`.
- `SDATA`  in  1  serial data.
- `port_id`  in  8  PicoBlaze port address.
- `read_strobe`  in  1  PicoBlaze input strobe, one cycle.
- `in_port`  out  8  registered read data.
- `word_ready`  out  1  FIFO not empty.
- `freq0`  out  28  assembled FREQ0 register. Present only with `DDS_RX_FREQ_EN`.
- `freq0_valid`  out  1  one-cycle pulse on `freq0` update. Present only with `DDS_RX_FREQ_EN`.

## Operation
- **Synchroniser:** `FSYNC`, `SCLK` and `SDATA` each pass through 2 flops. A falling SCLK edge is detected when the synced value is 0 and the previous synced value is 1. Data is taken from the synced `SDATA` in the same cycle.
- **State machine `IDLE` → `SHIFT` → `PUSH`:**
  - `IDLE`: synced FSYNC falling → `SHIFT`, bit count = 0.
  - `SHIFT`: each SCLK fall shifts the data bit into a 16-bit register (MSB first) and increments the 4-bit count. On the 16th bit → `PUSH`.
  - `PUSH`: write the word into the FIFO for one cycle. Then go to `SHIFT` if FSYNC is still low (back-to-back words, count wraps to 0), otherwise to `IDLE`.
  - FSYNC rises in `SHIFT` with count ≠ 0: set sticky `frame_err`, discard the partial word, go to `IDLE`. FSYNC rises with count = 0: go to `IDLE` silently.
- **FIFO:** a push when full drops the word and sets sticky `ovf`. A simultaneous pop and push when full succeeds, because the pop frees the slot. A pop when empty is ignored.
- **Read path:** every cycle, `in_port` is loaded from `port_id`:
  - +0 → head word [7:0]
  - +1 → head word [15:8]
  - +2 → status {4'b0, frame_err, ovf, full, !empty}
  - any other port → 8'h00
  - Empty FIFO reads as 8'h00.
- **Side effects on `read_strobe`:**
  - at +1: pop the FIFO.
  - at +2: clear `ovf` and `frame_err`. A set event in the same cycle wins.
- **Reset:** clears the FIFO, pointers, sticky bits and state (→ `IDLE`).
  - Output reset values: `in_port` = 8'h00, `word_ready` = 0, `freq0` = 0, `freq0_valid` = 0.
  - A frame in flight at reset is discarded. Reception resumes on the next FSYNC falling edge.

## Timing
- SCLK high and low phases must each be ≥ 3 `clk` periods. FSYNC setup to the first SCLK fall must be ≥ 3 `clk` periods.
- Latency from the SCLK fall at the pin to `word_ready` = 1 on an empty FIFO: 5 cycles (2 sync, 1 edge detect/shift, 1 `PUSH`, 1 flag register).
- `in_port` is valid 1 cycle after `port_id`, which matches the PicoBlaze 2-cycle INPUT.
- A pop takes effect on the cycle after `read_strobe`. `word_ready` updates in that same cycle.

## Configuration
- `DDS_RX_FREQ_EN` defined:
  - Each pushed word with D15:D14 = 01 is decoded as a FREQ0 write. D13:D0 is the payload.
  - The control-word bits are tracked from words with D15:D14 = 00: B28 = D13, HLB = D12.
  - With B28 = 1, the first FREQ0 word loads bits [13:0], the second loads [27:14], then `freq0` updates and `freq0_valid` pulses once.
  - With B28 = 0, each word replaces the half selected by HLB and pulses `freq0_valid`.
- `DDS_RX_FREQ_EN` undefined: `freq0`/`freq0_valid` ports and their logic are absent. FIFO behaviour is identical in both cases.

## Structure
- Shared package `dds_pkg`:
  - port offset constants (`DDS_RX_OFS_LO`/`HI`/`STAT`)
  - the status bit index constants
  - the state enum
  - the control-word bit positions (B28, HLB, FREQ0 address)
- Sub-module `dds_rx_fifo`: synchronous FIFO with `FIFO_DEPTH`, full/empty outputs and a registered head word.

## Test plan
- Send 16'hA5C3 in one FSYNC frame → `word_ready` = 1; read +0 returns 8'hC3; read +1 returns 8'hA5 and pops; `word_ready` = 0.
- Send 16'h1234 and 16'h5678 back-to-back with FSYNC held low → both are queued in order; status reads 8'h01.
- Send 5 words with `FIFO_DEPTH` = 4 and no reads → the 5th is dropped and status = 8'h07; reading status again returns 8'h03.
- Raise FSYNC after 9 bits → no push; status bit3 = 1; the next full frame 16'h00FF is received correctly.
- Assert `rst` mid-frame after 8 bits, then send a full frame 16'hBEEF → only 8'hEF/8'hBE are read; status after reset = 8'h00.
- With `DDS_RX_FREQ_EN`: send 16'h2000, 16'h4321, 16'h4ABC → `freq0` = 28'h2AF0321 with a single `freq0_valid` pulse.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS serial link receiver.
package dds_pkg;

  localparam logic [7:0] DDS_RX_OFS_LO   = 8'd0;
  localparam logic [7:0] DDS_RX_OFS_HI   = 8'd1;
  localparam logic [7:0] DDS_RX_OFS_STAT = 8'd2;

  localparam int DDS_RX_STAT_NEMPTY = 0;
  localparam int DDS_RX_STAT_FULL   = 1;
  localparam int DDS_RX_STAT_OVF    = 2;
  localparam int DDS_RX_STAT_FERR   = 3;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_PUSH  = 2'd2
  } rx_state_e;

  localparam int         DDS_B28_BIT    = 13;
  localparam int         DDS_HLB_BIT    = 12;
  localparam logic [1:0] DDS_ADDR_CTRL  = 2'b00;
  localparam logic [1:0] DDS_ADDR_FREQ0 = 2'b01;

endpackage

// File: rtl/dds_rx_fifo.sv
// Word FIFO for the DDS receiver; FIFO_DEPTH must be a power of two >= 2.
module dds_rx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [15:0] head,
  output logic        ovf_evt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop_ok, push_ok;

  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign ovf_evt = push && !push_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/dds_serial_rx.sv
// DDS 3-wire serial receiver with PicoBlaze input-port readout.
// Optional FREQ0 decode is built when DDS_RX_FREQ_EN is defined.
//
// state    | meaning
// RX_IDLE  | waiting for FSYNC falling edge
// RX_SHIFT | shifting bits on SCLK falls, MSB first
// RX_PUSH  | full word held, handed to the FIFO next cycle
module dds_serial_rx
  import dds_pkg::*;
#(
  parameter logic [7:0] BASE_PORT  = 8'h10,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       FSYNC,
  input  logic       SCLK,
  input  logic       SDATA,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic       word_ready
`ifdef DDS_RX_FREQ_EN
  ,
  output logic [27:0] freq0,
  output logic        freq0_valid
`endif
);

  localparam logic [7:0] PORT_LO   = BASE_PORT + DDS_RX_OFS_LO;
  localparam logic [7:0] PORT_HI   = BASE_PORT + DDS_RX_OFS_HI;
  localparam logic [7:0] PORT_STAT = BASE_PORT + DDS_RX_OFS_STAT;

  // Synchronisers are left unreset so a frame in flight during reset
  // does not look like a fresh FSYNC fall afterwards.
  logic fsync_meta_q, fsync_sync_q, fsync_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic sdata_meta_q, sdata_sync_q;

  always_ff @(posedge clk) begin
    fsync_meta_q <= FSYNC;
    fsync_sync_q <= fsync_meta_q;
    fsync_prev_q <= fsync_sync_q;
    sclk_meta_q  <= SCLK;
    sclk_sync_q  <= sclk_meta_q;
    sclk_prev_q  <= sclk_sync_q;
    sdata_meta_q <= SDATA;
    sdata_sync_q <= sdata_meta_q;
  end

  logic sclk_fall, fsync_fall;
  assign sclk_fall  = !sclk_sync_q && sclk_prev_q;
  assign fsync_fall = !fsync_sync_q && fsync_prev_q;

  rx_state_e   state_q;
  logic [3:0]  bit_cnt_q;
  logic [15:0] shreg_q, push_word_q;
  logic        push_q, ferr_evt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      push_word_q <= '0;
      push_q      <= 1'b0;
      ferr_evt_q  <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_evt_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (fsync_fall) begin
            state_q   <= RX_SHIFT;
            bit_cnt_q <= '0;
          end
        end
        RX_SHIFT: begin
          if (fsync_sync_q) begin
            ferr_evt_q <= (bit_cnt_q != 4'd0);
            state_q    <= RX_IDLE;
          end else if (sclk_fall) begin
            shreg_q   <= {shreg_q[14:0], sdata_sync_q};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd15) state_q <= RX_PUSH;
          end
        end
        RX_PUSH: begin
          push_q      <= 1'b1;
          push_word_q <= shreg_q;
          bit_cnt_q   <= '0;
          state_q     <= fsync_sync_q ? RX_IDLE : RX_SHIFT;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  logic        fifo_full, fifo_empty, fifo_ovf_evt, fifo_pop;
  logic [15:0] fifo_head;

  assign fifo_pop = read_strobe && (port_id == PORT_HI);

  dds_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_word_q),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .ovf_evt   (fifo_ovf_evt)
  );

  logic       ovf_q, ovf_d, ferr_q, ferr_d;
  logic [7:0] in_port_q, in_port_d, status;

  always_comb begin
    status = 8'h00;
    status[DDS_RX_STAT_NEMPTY] = !fifo_empty;
    status[DDS_RX_STAT_FULL]   = fifo_full;
    status[DDS_RX_STAT_OVF]    = ovf_q;
    status[DDS_RX_STAT_FERR]   = ferr_q;

    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    if (read_strobe && (port_id == PORT_STAT)) begin
      ovf_d  = 1'b0;
      ferr_d = 1'b0;
    end
    if (fifo_ovf_evt) ovf_d  = 1'b1;
    if (ferr_evt_q)   ferr_d = 1'b1;

    in_port_d = 8'h00;
    if (port_id == PORT_LO)        in_port_d = fifo_empty ? 8'h00 : fifo_head[7:0];
    else if (port_id == PORT_HI)   in_port_d = fifo_empty ? 8'h00 : fifo_head[15:8];
    else if (port_id == PORT_STAT) in_port_d = status;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      in_port_q <= 8'h00;
    end else begin
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
      in_port_q <= in_port_d;
    end
  end

  assign in_port    = in_port_q;
  assign word_ready = !fifo_empty;

`ifdef DDS_RX_FREQ_EN
  logic        b28_q, b28_d, hlb_q, hlb_d, half_q, half_d;
  logic        freq0_valid_q, freq0_valid_d;
  logic [13:0] lsb_q, lsb_d;
  logic [27:0] freq0_q, freq0_d;

  always_comb begin
    b28_d         = b28_q;
    hlb_d         = hlb_q;
    half_d        = half_q;
    lsb_d         = lsb_q;
    freq0_d       = freq0_q;
    freq0_valid_d = 1'b0;
    if (push_q) begin
      if (push_word_q[15:14] == DDS_ADDR_CTRL) begin
        b28_d  = push_word_q[DDS_B28_BIT];
        hlb_d  = push_word_q[DDS_HLB_BIT];
        half_d = 1'b0;
      end else if (push_word_q[15:14] == DDS_ADDR_FREQ0) begin
        if (b28_q) begin
          if (!half_q) begin
            lsb_d  = push_word_q[13:0];
            half_d = 1'b1;
          end else begin
            freq0_d       = {push_word_q[13:0], lsb_q};
            freq0_valid_d = 1'b1;
            half_d        = 1'b0;
          end
        end else begin
          if (hlb_q) freq0_d[27:14] = push_word_q[13:0];
          else       freq0_d[13:0]  = push_word_q[13:0];
          freq0_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b28_q         <= 1'b0;
      hlb_q         <= 1'b0;
      half_q        <= 1'b0;
      lsb_q         <= '0;
      freq0_q       <= '0;
      freq0_valid_q <= 1'b0;
    end else begin
      b28_q         <= b28_d;
      hlb_q         <= hlb_d;
      half_q        <= half_d;
      lsb_q         <= lsb_d;
      freq0_q       <= freq0_d;
      freq0_valid_q <= freq0_valid_d;
    end
  end

  assign freq0       = freq0_q;
  assign freq0_valid = freq0_valid_q;
`endif

endmodule
